// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared mode constants for the up/down counter
// Purpose: limit-behaviour selector used by updown_counter_param and its helper.
// Contents: mode_e (MODE_WRAP = 0, MODE_SAT = 1).
package updown_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage

// File: rtl/updown_limit_next.sv
// rtl/updown_limit_next.sv - limit detection and next-count selection
// Purpose: decides where an enabled step lands, given the current count and direction.
// Ports:
//   qout     in   current count
//   updown   in   1 = up, 0 = down
//   at_max   out  count equals MAX_VAL
//   at_min   out  count equals 0
//   step_val out  count after an enabled step (wrapped or held at a limit)
//   crossing out  the step hits a limit (wrap in MODE_WRAP, blocked in MODE_SAT)
module updown_limit_next
    import updown_counter_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1,
    parameter mode_e            MODE    = MODE_WRAP
) (
    input  logic [WIDTH-1:0] qout,
    input  logic             updown,
    output logic             at_max,
    output logic             at_min,
    output logic [WIDTH-1:0] step_val,
    output logic             crossing
);

    always_comb begin
        at_max   = (qout == MAX_VAL);
        at_min   = (qout == '0);
        crossing = updown ? at_max : at_min;
        step_val = qout;
        if (updown) begin
            if (!at_max) begin
                step_val = qout + 1'b1;
            end else if (MODE == MODE_WRAP) begin
                step_val = '0;
            end
        end else begin
            if (!at_min) begin
                step_val = qout - 1'b1;
            end else if (MODE == MODE_WRAP) begin
                step_val = MAX_VAL;
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parameterised up/down counter with wrap or saturate limits
// Purpose: WIDTH-bit counter bounded to 0..MAX_VAL with clear > load > en priority.
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   clear     in   synchronous clear to 0
//   load      in   synchronous load of min(load_val, MAX_VAL)
//   load_val  in   load data
//   en        in   count enable
//   updown    in   1 = up, 0 = down
//   Qout      out  registered count
//   tc        out  terminal count for the current direction (combinational)
//   wrap      out  registered pulse on a limit crossing / blocked step
//   sat       out  registered level while held at a limit (MODE_SAT only)
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter mode_e           MODE    = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             updown,
    output logic [WIDTH-1:0] Qout,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be 2..32");
    end
    if (MAX_VAL == 0 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max_val
        $error("updown_counter_param: MAX_VAL must be 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] qout_q, qout_d;
    logic             wrap_q, wrap_d;
    logic             sat_q,  sat_d;

    logic             at_max, at_min, crossing;
    logic [WIDTH-1:0] step_val;

    updown_limit_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_W),
        .MODE    (MODE)
    ) u_limit_next (
        .qout     (qout_q),
        .updown   (updown),
        .at_max   (at_max),
        .at_min   (at_min),
        .step_val (step_val),
        .crossing (crossing)
    );

    always_comb begin
        qout_d = qout_q;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        if (clear) begin
            qout_d = '0;
            sat_d  = 1'b0;
        end else if (load) begin
            // Clamp so an out-of-range load can never push the count past MAX_VAL.
            qout_d = (load_val > MAX_W) ? MAX_W : load_val;
            sat_d  = 1'b0;
        end else if (en) begin
            qout_d = step_val;
            wrap_d = crossing;
            // In wrap mode a crossing is a wrap, never a hold, so sat stays low.
            sat_d  = (MODE == MODE_SAT) && crossing;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qout_q <= '0;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            qout_q <= qout_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

    assign Qout = qout_q;
    assign wrap = wrap_q;
    assign sat  = sat_q;
    assign tc   = updown ? at_max : at_min;

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - self-checking bench for updown_counter_param
module tb_updown_counter_param;
    import updown_counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear, load, en, updown;
    logic [7:0] load_val8;
    logic [3:0] load_val4;

    logic [7:0] q8;
    logic [3:0] q4w, q4s;
    logic       tc8, tc4w, tc4s;
    logic       wr8, wr4w, wr4s;
    logic       st8, st4w, st4s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(8), .MODE(MODE_WRAP)) dut8 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val8),
        .en(en), .updown(updown), .Qout(q8), .tc(tc8), .wrap(wr8), .sat(st8));

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP)) dut4w (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val4),
        .en(en), .updown(updown), .Qout(q4w), .tc(tc4w), .wrap(wr4w), .sat(st4w));

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_SAT)) dut4s (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val4),
        .en(en), .updown(updown), .Qout(q4s), .tc(tc4s), .wrap(wr4s), .sat(st4s));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic c, input logic l, input logic [7:0] lv8,
                          input logic [3:0] lv4, input logic e, input logic u);
        clear = c; load = l; load_val8 = lv8; load_val4 = lv4; en = e; updown = u;
    endtask

    task automatic model_step(input int q, input bit s, input int maxv, input bit satm,
                              input int lv, output int qn, output bit wn, output bit sn);
        qn = q; wn = 1'b0; sn = s;
        if (clear) begin
            qn = 0; sn = 1'b0;
        end else if (load) begin
            qn = (lv > maxv) ? maxv : lv; sn = 1'b0;
        end else if (en) begin
            sn = 1'b0;
            if (updown) begin
                if (q == maxv) begin
                    wn = 1'b1;
                    if (satm) sn = 1'b1; else qn = 0;
                end else qn = q + 1;
            end else begin
                if (q == 0) begin
                    wn = 1'b1;
                    if (satm) sn = 1'b1; else qn = maxv;
                end else qn = q - 1;
            end
        end
    endtask

    initial begin : stim
        int   exp_q;
        int   qe[5];
        bit   se[5];
        int   mq[3];
        bit   mw[3], ms[3];
        int   maxv[3];
        bit   satm[3];
        int   lv;
        logic [63:0] oq, ow, os, ot;

        reset_n = 1'b0;
        set_in(0, 0, 8'd0, 4'd0, 0, 1);
        tick; tick;
        chk("rst_q8", 64'(q8), 0);
        chk("rst_wrap8", 64'(wr8), 0);
        chk("rst_q4s", 64'(q4s), 0);
        chk("rst_sat4s", 64'(st4s), 0);

        // 8-bit wrap count-up over 260 edges
        reset_n = 1'b1;
        set_in(0, 0, 8'd0, 4'd0, 1, 1);
        for (int i = 1; i <= 260; i++) begin
            tick;
            chk("up8_q", 64'(q8), 64'(i % 256));
            chk("up8_wrap", 64'(wr8), 64'(i == 256));
        end

        set_in(1, 0, 8'd0, 4'd0, 0, 1);
        tick;
        chk("clr_q8", 64'(q8), 0);
        chk("clr_q4w", 64'(q4w), 0);

        // MAX_VAL=9 wrap, counting down from 0
        set_in(0, 0, 8'd0, 4'd0, 1, 0);
        #1;
        chk("dn4_tc_at0", 64'(tc4w), 1);
        for (int k = 1; k <= 12; k++) begin
            tick;
            exp_q = (10 - (k % 10)) % 10;
            chk("dn4_q", 64'(q4w), 64'(exp_q));
            chk("dn4_wrap", 64'(wr4w), 64'(k % 10 == 1));
            chk("dn4_tc", 64'(tc4w), 64'(exp_q == 0));
            chk("dn4_sat", 64'(st4w), 0);
        end

        // MAX_VAL=9 saturate
        set_in(0, 1, 8'd0, 4'd7, 0, 1);
        tick;
        chk("sat_load7", 64'(q4s), 7);
        qe = '{8, 9, 9, 9, 9};
        se = '{0, 0, 1, 1, 1};
        set_in(0, 0, 8'd0, 4'd0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("sat_q", 64'(q4s), 64'(qe[k]));
            chk("sat_sat", 64'(st4s), 64'(se[k]));
            chk("sat_wrap", 64'(wr4s), 64'(se[k]));
        end
        chk("sat_tc", 64'(tc4s), 1);
        updown = 1'b0;
        tick;
        chk("sat_rev_q", 64'(q4s), 8);
        chk("sat_rev_sat", 64'(st4s), 0);
        chk("sat_rev_wrap", 64'(wr4s), 0);

        // Priority clear > load > en, then load clamp
        set_in(1, 1, 8'd5, 4'd5, 1, 1);
        tick;
        chk("prio_clr_q4s", 64'(q4s), 0);
        chk("prio_clr_q8", 64'(q8), 0);
        set_in(0, 1, 8'd5, 4'd5, 0, 1);
        tick;
        chk("prio_load5", 64'(q4s), 5);
        set_in(0, 1, 8'd12, 4'd12, 1, 1);
        tick;
        chk("clamp_q4s", 64'(q4s), 9);
        chk("clamp_q4w", 64'(q4w), 9);
        chk("noclamp_q8", 64'(q8), 12);

        // Direction change at MAX_VAL steps away without a wrap
        set_in(0, 0, 8'd0, 4'd0, 1, 0);
        #1;
        chk("dir_tc_before", 64'(tc4w), 0);
        tick;
        chk("dir_q4w", 64'(q4w), 8);
        chk("dir_wrap4w", 64'(wr4w), 0);

        // Asynchronous reset mid-count
        set_in(0, 1, 8'd99, 4'd0, 0, 1);
        tick;
        set_in(0, 0, 8'd0, 4'd0, 1, 1);
        tick;
        chk("ar_q100", 64'(q8), 100);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_q8_now", 64'(q8), 0);
        chk("ar_q4w_now", 64'(q4w), 0);
        tick;
        reset_n = 1'b1;
        tick;
        chk("ar_resume", 64'(q8), 1);

        // Random run against the reference model
        set_in(1, 0, 8'd0, 4'd0, 0, 1);
        tick;
        maxv = '{255, 9, 9};
        satm = '{0, 0, 1};
        for (int j = 0; j < 3; j++) begin
            mq[j] = 0; mw[j] = 0; ms[j] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            clear     = ($urandom_range(0, 63) == 0);
            load      = ($urandom_range(0, 31) == 0);
            en        = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) updown = ~updown;
            load_val8 = 8'($urandom_range(0, 255));
            load_val4 = 4'($urandom_range(0, 15));
            for (int j = 0; j < 3; j++) begin
                lv = (j == 0) ? int'(load_val8) : int'(load_val4);
                model_step(mq[j], ms[j], maxv[j], satm[j], lv, mq[j], mw[j], ms[j]);
            end
            tick;
            for (int j = 0; j < 3; j++) begin
                case (j)
                    0:       begin oq = 64'(q8);  ow = 64'(wr8);  os = 64'(st8);  ot = 64'(tc8);  end
                    1:       begin oq = 64'(q4w); ow = 64'(wr4w); os = 64'(st4w); ot = 64'(tc4w); end
                    default: begin oq = 64'(q4s); ow = 64'(wr4s); os = 64'(st4s); ot = 64'(tc4s); end
                endcase
                chk($sformatf("rnd%0d_q_c%0d", j, c), oq, 64'(mq[j]));
                chk($sformatf("rnd%0d_wrap_c%0d", j, c), ow, 64'(mw[j]));
                chk($sformatf("rnd%0d_sat_c%0d", j, c), os, 64'(ms[j]));
                chk($sformatf("rnd%0d_tc_c%0d", j, c), ot,
                    64'(updown ? (mq[j] == maxv[j]) : (mq[j] == 0)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
